// File: rtl/bcd_timer_core.sv
// rtl/bcd_timer_core.sv - N-digit BCD up/down timer with preset load, pause and done/expired flags
// Define BCD_TIMER_LAP_EN to enable the lap (display freeze) feature.
module bcd_timer_core #(
  parameter int          DIGITS         = 2,
  parameter logic [31:0] DEFAULT_PRESET = 32'h25
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                btn_start,
  input  logic                btn_clr,
  input  logic                mode_up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                lap,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                running,
  output logic                done,
  output logic                expired
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] PRESET_INIT = DEFAULT_PRESET[W-1:0];

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]   state, state_nxt;
  logic [W-1:0] preset_reg, preset_nxt;
  logic [W-1:0] count, count_nxt;
  logic         mode_reg, mode_nxt;
  logic         done_nxt;
  logic [W-1:0] out_nxt;
  logic [W-1:0] start_val, stepped, terminal, load_clamped;

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  always_comb begin
    state_nxt    = state;
    preset_nxt   = preset_reg;
    count_nxt    = count;
    mode_nxt     = mode_reg;
    done_nxt     = 1'b0;
    start_val    = mode_up ? '0 : preset_reg;
    stepped      = mode_reg ? bcd_inc(count) : bcd_dec(count);
    terminal     = mode_reg ? preset_reg : '0;
    load_clamped = bcd_clamp(load_val);

    if (btn_clr) begin
      state_nxt = S_IDLE;
      mode_nxt  = mode_up;
      count_nxt = start_val;
    end else if (load && (state == S_IDLE || state == S_DONE)) begin
      // Use the clamped value directly so the display reflects the load at once.
      state_nxt  = S_IDLE;
      mode_nxt   = mode_up;
      preset_nxt = load_clamped;
      count_nxt  = mode_up ? '0 : load_clamped;
    end else begin
      case (state)
        S_IDLE: begin
          mode_nxt  = mode_up;
          count_nxt = start_val;
          if (btn_start) begin
            if (preset_reg == '0) begin
              state_nxt = S_DONE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (btn_start) begin
            state_nxt = S_PAUSE;
          end else if (tick) begin
            count_nxt = stepped;
            if (stepped == terminal) begin
              state_nxt = S_DONE;
              done_nxt  = 1'b1;
            end
          end
        end
        S_PAUSE: begin
          if (btn_start) state_nxt = S_RUN;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef BCD_TIMER_LAP_EN
  logic         lap_frozen, frozen_nxt;
  logic [W-1:0] lap_val, lap_val_nxt;

  always_comb begin
    frozen_nxt  = lap_frozen;
    lap_val_nxt = lap_val;
    if (state_nxt == S_IDLE || state_nxt == S_DONE) begin
      frozen_nxt = 1'b0;
    end else if (lap && (state == S_RUN || state == S_PAUSE)) begin
      frozen_nxt  = !lap_frozen;
      lap_val_nxt = count;
    end
    out_nxt = frozen_nxt ? lap_val_nxt : count_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_frozen <= 1'b0;
      lap_val    <= PRESET_INIT;
    end else begin
      lap_frozen <= frozen_nxt;
      lap_val    <= lap_val_nxt;
    end
  end
`else
  logic unused_lap;
  assign unused_lap = lap;

  always_comb begin
    out_nxt = count_nxt;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      preset_reg <= PRESET_INIT;
      count      <= PRESET_INIT;
      mode_reg   <= 1'b0;
      bcd_out    <= PRESET_INIT;
      running    <= 1'b0;
      done       <= 1'b0;
      expired    <= 1'b0;
    end else begin
      state      <= state_nxt;
      preset_reg <= preset_nxt;
      count      <= count_nxt;
      mode_reg   <= mode_nxt;
      bcd_out    <= out_nxt;
      running    <= (state_nxt == S_RUN);
      done       <= done_nxt;
      expired    <= (state_nxt == S_DONE);
    end
  end

endmodule
